// File: rtl/bht_pkg.sv
// Shared definitions for the gshare branch history table: 2-bit counter
// encodings, the reset counter value and the saturating update.
package bht_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RESET = WNT;

    // Saturating step toward the resolved direction
    function automatic ctr_e ctr_update(input ctr_e ctr, input logic taken);
        ctr_e nxt;
        case (ctr)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = CTR_RESET;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bht.sv
// Gshare direction predictor: global history register XORed with the PC
// indexes a flop-based table of 2-bit saturating counters.
module bht
    import bht_pkg::*;
#(
    parameter int INDEX_WIDTH = 6,
    parameter int GHR_WIDTH   = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 prediction_en,
    input  logic                 PL_flush,
    input  logic                 branch_if,
    input  logic [31:0]          pc_if,
    output logic                 prediction_taken,
    output logic [GHR_WIDTH-1:0] ghr_if,
    input  logic                 branch_ex,
    input  logic [31:0]          pc_ex,
    input  logic [GHR_WIDTH-1:0] ghr_ex,
    input  logic                 taken_ex
);

    localparam int ENTRIES = 1 << INDEX_WIDTH;

    ctr_e                   table_r [ENTRIES];
    logic [GHR_WIDTH-1:0]   ghr_r;
    logic [INDEX_WIDTH-1:0] ghr_if_ext_s;
    logic [INDEX_WIDTH-1:0] ghr_ex_ext_s;
    logic [INDEX_WIDTH-1:0] lkp_idx_s;
    logic [INDEX_WIDTH-1:0] upd_idx_s;
    logic                   predict_s;
    logic                   unused_s;

    assign ghr_if = ghr_r;

    // Zero-extend both history values to table index width
    always_comb begin
        ghr_if_ext_s                = '0;
        ghr_ex_ext_s                = '0;
        ghr_if_ext_s[GHR_WIDTH-1:0] = ghr_r;
        ghr_ex_ext_s[GHR_WIDTH-1:0] = ghr_ex;
    end

    assign lkp_idx_s = pc_if[INDEX_WIDTH+1:2] ^ ghr_if_ext_s;
    assign upd_idx_s = pc_ex[INDEX_WIDTH+1:2] ^ ghr_ex_ext_s;
    assign predict_s = prediction_en & branch_if;

    // Lookup reads the pre-edge table, so a same-cycle update is seen next cycle
    always_comb begin
        if (predict_s) begin
            prediction_taken = table_r[lkp_idx_s][1];
        end else begin
            prediction_taken = 1'b0;
        end
    end

    // Counter training on every resolved branch, independent of flush/enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_r[i] <= CTR_RESET;
            end
        end else if (branch_ex) begin
            table_r[upd_idx_s] <= ctr_update(table_r[upd_idx_s], taken_ex);
        end
    end

    // History: flush repair outranks the speculative shift; bare flush holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_r <= '0;
        end else if (PL_flush) begin
            if (branch_ex) begin
                ghr_r <= {ghr_ex[GHR_WIDTH-2:0], taken_ex};
            end else begin
                ghr_r <= ghr_r;
            end
        end else if (predict_s) begin
            ghr_r <= {ghr_r[GHR_WIDTH-2:0], prediction_taken};
        end else begin
            ghr_r <= ghr_r;
        end
    end

    assign unused_s = ^{pc_if[31:INDEX_WIDTH+2], pc_if[1:0],
                        pc_ex[31:INDEX_WIDTH+2], pc_ex[1:0]};

endmodule

// File: tb/tb_bht.sv
// Directed-vector bench for the gshare BHT with hand-computed expectations.
module tb_bht;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prediction_en;
    logic        PL_flush;
    logic        branch_if;
    logic [31:0] pc_if;
    logic        prediction_taken;
    logic [5:0]  ghr_if;
    logic        branch_ex;
    logic [31:0] pc_ex;
    logic [5:0]  ghr_ex;
    logic        taken_ex;

    int checks = 0;
    int errors = 0;

    bht #(.INDEX_WIDTH(6), .GHR_WIDTH(6)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .prediction_en    (prediction_en),
        .PL_flush         (PL_flush),
        .branch_if        (branch_if),
        .pc_if            (pc_if),
        .prediction_taken (prediction_taken),
        .ghr_if           (ghr_if),
        .branch_ex        (branch_ex),
        .pc_ex            (pc_ex),
        .ghr_ex           (ghr_ex),
        .taken_ex         (taken_ex)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Combinational lookup that leaves no branch_if asserted at the next edge
    task automatic peek(input string tag, input logic [31:0] pc, input logic en, input logic exp);
        pc_if         = pc;
        branch_if     = 1'b1;
        prediction_en = en;
        #1;
        check(tag, {31'd0, prediction_taken}, {31'd0, exp});
        branch_if     = 1'b0;
        prediction_en = 1'b0;
    endtask

    // One counter update through the EX port, no flush
    task automatic train(input logic [31:0] pc, input logic [5:0] g, input logic t);
        branch_ex = 1'b1;
        pc_ex     = pc;
        ghr_ex    = g;
        taken_ex  = t;
        tick();
        branch_ex = 1'b0;
    endtask

    logic sat_exp [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        rst_n = 1'b0; prediction_en = 1'b0; PL_flush = 1'b0; branch_if = 1'b0;
        pc_if = 32'd0; branch_ex = 1'b0; pc_ex = 32'd0; ghr_ex = 6'd0; taken_ex = 1'b0;
        #1;
        check("rst_ghr", {26'd0, ghr_if}, 32'd0);
        peek("rst_pred_0", 32'h0000_0000, 1'b1, 1'b0);
        peek("rst_pred_40", 32'h0000_0040, 1'b1, 1'b0);
        #20 rst_n = 1'b1;
        tick();

        // Saturation at entry 0: 4 taken then 4 not-taken
        for (int i = 0; i < 8; i++) begin
            train(32'h0000_0100, 6'd0, (i < 4) ? 1'b1 : 1'b0);
            peek($sformatf("sat_%0d", i), 32'h0000_0100, 1'b1, sat_exp[i]);
        end
        train(32'h0000_0100, 6'd0, 1'b1);
        peek("sat_floor_up1", 32'h0000_0100, 1'b1, 1'b0);
        train(32'h0000_0100, 6'd0, 1'b1);
        peek("sat_floor_up2", 32'h0000_0100, 1'b1, 1'b1);
        check("sat_ghr_held", {26'd0, ghr_if}, 32'd0);

        // Read-during-write at entry 16
        pc_if = 32'h0000_0040; branch_if = 1'b1; prediction_en = 1'b1;
        branch_ex = 1'b1; pc_ex = 32'h0000_0040; ghr_ex = 6'd0; taken_ex = 1'b1;
        #1;
        check("rdw_same", {31'd0, prediction_taken}, 32'd0);
        tick();
        branch_ex = 1'b0;
        check("rdw_next", {31'd0, prediction_taken}, 32'd1);
        branch_if = 1'b0; prediction_en = 1'b0;
        peek("pred_en_low", 32'h0000_0040, 1'b0, 1'b0);
        check("rdw_ghr", {26'd0, ghr_if}, 32'd0);

        // Aliasing: (pc 0x4, ghr 1) and (pc 0x0, ghr 0) both hit entry 0
        peek("alias_pc0_before", 32'h0000_0000, 1'b1, 1'b1);
        PL_flush = 1'b1;
        train(32'h0000_0080, 6'd0, 1'b1);
        PL_flush = 1'b0;
        check("alias_ghr1", {26'd0, ghr_if}, 32'd1);
        peek("alias_pc4_before", 32'h0000_0004, 1'b1, 1'b1);
        train(32'h0000_0004, 6'd1, 1'b0);
        peek("alias_pc4_after", 32'h0000_0004, 1'b1, 1'b0);
        PL_flush = 1'b1;
        train(32'h0000_0080, 6'd0, 1'b0);
        PL_flush = 1'b0;
        check("alias_ghr0", {26'd0, ghr_if}, 32'd0);
        peek("alias_pc0_after", 32'h0000_0000, 1'b1, 1'b0);

        // Speculative shift with predictions 1,0,1
        branch_if = 1'b1; prediction_en = 1'b1;
        pc_if = 32'h0000_0040; #1;
        check("spec_pred0", {31'd0, prediction_taken}, 32'd1);
        tick();
        check("spec_ghr1", {26'd0, ghr_if}, 32'h01);
        pc_if = 32'h0000_0008; #1;
        check("spec_pred1", {31'd0, prediction_taken}, 32'd0);
        tick();
        check("spec_ghr2", {26'd0, ghr_if}, 32'h02);
        pc_if = 32'h0000_0048; #1;
        check("spec_pred2", {31'd0, prediction_taken}, 32'd1);
        tick();
        check("spec_ghr3", {26'd0, ghr_if}, 32'h05);
        branch_if = 1'b0;
        tick();
        check("spec_hold", {26'd0, ghr_if}, 32'h05);

        // Repair outranks speculative shift
        branch_if = 1'b1; prediction_en = 1'b1; pc_if = 32'h0000_0040; PL_flush = 1'b1;
        train(32'h0000_00C0, 6'b101010, 1'b1);
        check("repair", {26'd0, ghr_if}, 32'h15);
        tick();
        check("flush_no_ex_hold", {26'd0, ghr_if}, 32'h15);
        PL_flush = 1'b0; prediction_en = 1'b0;
        tick();
        check("pred_dis_hold", {26'd0, ghr_if}, 32'h15);
        branch_if = 1'b0;

        // Mid-cycle reset discards the pending update; first edge after release trains
        branch_ex = 1'b1; pc_ex = 32'h0000_0100; ghr_ex = 6'd0; taken_ex = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ghr", {26'd0, ghr_if}, 32'd0);
        peek("midrst_pred", 32'h0000_0040, 1'b1, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        peek("postrst_entry0", 32'h0000_0000, 1'b1, 1'b0);
        tick();
        branch_ex = 1'b0;
        peek("postrst_first_upd", 32'h0000_0000, 1'b1, 1'b1);
        check("postrst_ghr", {26'd0, ghr_if}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bht.md
BHT -- requirements
Module: bht

Interface
REQ-001 Parameter INDEX_WIDTH, default 6, log2 of pattern-table entries (64 entries).
REQ-002 Parameter GHR_WIDTH, default 6, global history length; SHALL be <= INDEX_WIDTH.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 prediction_en  input  1  enables prediction and speculative history shift.
REQ-006 PL_flush  input  1  pipeline flush from EX misprediction.
REQ-007 branch_if  input  1  IF-stage instruction is a conditional branch.
REQ-008 pc_if  input  32  IF-stage PC.
REQ-009 prediction_taken  output  1  predicted direction for pc_if, consumed by next-PC select beside RAS jalr target.
REQ-010 ghr_if  output  GHR_WIDTH  current history snapshot, carried down the pipeline with the branch.
REQ-011 branch_ex  input  1  EX-stage conditional branch resolved this cycle.
REQ-012 pc_ex  input  32  EX-stage branch PC.
REQ-013 ghr_ex  input  GHR_WIDTH  snapshot carried with the EX branch.
REQ-014 taken_ex  input  1  actual EX outcome.

Function
REQ-015 Lookup index SHALL be pc_if[INDEX_WIDTH+1:2] XOR zero-extended ghr_if; update index SHALL be pc_ex[INDEX_WIDTH+1:2] XOR zero-extended ghr_ex.
REQ-016 Each entry SHALL be a 2-bit saturating counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-017 prediction_taken SHALL be combinational, same cycle as pc_if: counter[1] when prediction_en && branch_if, else 0.
REQ-018 On branch_ex at clock edge, counter at update index SHALL increment if taken_ex (saturate at 11) else decrement (saturate at 00), regardless of PL_flush or prediction_en.
REQ-019 Lookup and update at the same index in one cycle: prediction SHALL use the pre-update value; new value visible next cycle.
REQ-020 When PL_flush && branch_ex, GHR SHALL load {ghr_ex[GHR_WIDTH-2:0], taken_ex} (repair).
REQ-021 When PL_flush without branch_ex (e.g. jalr mispredict), GHR SHALL hold.
REQ-022 When !PL_flush && prediction_en && branch_if, GHR SHALL shift left, inserting prediction_taken at bit 0.
REQ-023 Otherwise GHR SHALL hold; flush repair SHALL take priority over speculative shift in the same cycle.
REQ-024 ghr_if SHALL equal the GHR register (pre-shift value for the branch being looked up).
REQ-025 With prediction_en low, counters SHALL still train per REQ-018; GHR updates only via REQ-020.

Reset
REQ-026 On rst_n low, asynchronously: GHR = 0, every counter = 01 (weak-NT), hence prediction_taken = 0.
REQ-027 Reset asserted mid-operation SHALL discard any same-edge update; first update is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-028 Shared package SHALL hold the counter encodings SNT/WNT/WT/ST, the reset counter value, and a saturating 2-bit update function.
REQ-029 Pattern table SHALL be a flop array (async reset required, so no RAM macro); no sub-module; GHR and table in one module of roughly 150-250 lines.

Verification
REQ-030 Reset: drive rst_n=0 mid-cycle -> ghr_if=0 immediately, prediction_taken=0 for any pc_if with branch_if=1.
REQ-031 Saturation: GHR held at 0, pc_ex=0x100, taken_ex=1 on 4 consecutive branch_ex -> counter 01->10->11->11, prediction_taken for pc_if=0x100 becomes 1 after the first update; then 4x taken_ex=0 -> 11->10->01->00->00.
REQ-032 Speculative shift: prediction_en=1, branch_if=1 for 3 cycles with predictions 1,0,1 -> ghr_if goes 000000->000001->000010->000101.
REQ-033 Repair priority: same cycle branch_if=1, PL_flush=1, branch_ex=1, ghr_ex=6'b101010, taken_ex=1 -> next ghr_if = 6'b010101, no speculative bit inserted.
REQ-034 Read-during-write: pc_if=pc_ex=0x40, counter=01, taken_ex=1 -> prediction_taken=0 that cycle, 1 next cycle.
REQ-035 Index aliasing: pc_if=0x4, ghr=1 and pc_if=0x0, ghr=0 -> both address entry 0; training one SHALL change the other's prediction.
